// File: rtl/pm_univ_reg.sv
// pm_univ_reg: WIDTH-bit universal register (load/shift/rotate/count) with carry-out and zero flags
module pm_univ_reg #(
  parameter int          WIDTH     = 4,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             zero
);
  localparam logic [WIDTH-1:0] RV  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH:0]   ONE = 1;
  logic [WIDTH-1:0] q_n;
  logic             c_n;
  // Counting runs one bit wider so the extra MSB is the carry/borrow.
  always_comb begin
    q_n = q;
    c_n = cout;
    case (mode)
      3'b001: {c_n, q_n} = {1'b0, d};
      3'b010: {c_n, q_n} = {q, sin};
      3'b011: {q_n, c_n} = {sin, q};
      3'b100: {c_n, q_n} = {1'b0, q} + ONE;
      3'b101: {c_n, q_n} = {1'b0, q} - ONE;
      3'b110: {c_n, q_n} = {q, q[WIDTH-1]};
      3'b111: {q_n, c_n} = {q[0], q};
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      q    <= RV;
      cout <= 1'b0;
    end else if (ce) begin
      q    <= q_n;
      cout <= c_n;
    end
  end
  assign zero = ~|q;
endmodule

// File: tb/tb_pm_univ_reg.sv
// tb_pm_univ_reg: directed vectors for a 4-bit and an 8-bit (RESET_VAL=5A) instance
module tb_pm_univ_reg;
  logic       clk = 1'b0;
  logic       clr4, ce4, sin4, clr8, ce8, sin8;
  logic [2:0] mode4, mode8;
  logic [3:0] d4, q4;
  logic [7:0] d8, q8;
  logic       c4, z4, c8, z8;
  int         vectors = 0;
  int         miscompares = 0;

  pm_univ_reg #(.WIDTH(4), .RESET_VAL(32'd0)) u4 (
    .clk(clk), .clr(clr4), .ce(ce4), .mode(mode4), .d(d4), .sin(sin4),
    .q(q4), .cout(c4), .zero(z4)
  );
  pm_univ_reg #(.WIDTH(8), .RESET_VAL(32'h5A)) u8 (
    .clk(clk), .clr(clr8), .ce(ce8), .mode(mode8), .d(d8), .sin(sin8),
    .q(q8), .cout(c8), .zero(z8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic s4(input logic c, input logic e, input logic [2:0] m, input logic [3:0] dd,
                    input logic s, input string tag, input logic [3:0] eq, input logic ec);
    clr4 = c; ce4 = e; mode4 = m; d4 = dd; sin4 = s;
    @(posedge clk); #1;
    chk({tag, ".q"}, 32'(q4), 32'(eq));
    chk({tag, ".cout"}, 32'(c4), 32'(ec));
    chk({tag, ".zero"}, 32'(z4), 32'(eq == 4'd0));
  endtask

  task automatic s8(input logic c, input logic e, input logic [2:0] m, input logic [7:0] dd,
                    input logic s, input string tag, input logic [7:0] eq, input logic ec);
    clr8 = c; ce8 = e; mode8 = m; d8 = dd; sin8 = s;
    @(posedge clk); #1;
    chk({tag, ".q"}, 32'(q8), 32'(eq));
    chk({tag, ".cout"}, 32'(c8), 32'(ec));
    chk({tag, ".zero"}, 32'(z8), 32'(eq == 8'd0));
  endtask

  initial begin
    clr8 = 1'b1; ce8 = 1'b0; mode8 = 3'd0; d8 = 8'h00; sin8 = 1'b0;
    s4(1, 1, 3'b001, 4'hA, 0, "clr_over_load", 4'h0, 0);
    s4(0, 1, 3'b001, 4'hE, 0, "load_E",  4'hE, 0);
    s4(0, 1, 3'b100, 4'h3, 1, "inc_F",   4'hF, 0);
    s4(0, 1, 3'b100, 4'h3, 1, "inc_wrap", 4'h0, 1);
    s4(0, 1, 3'b100, 4'h3, 1, "inc_1",   4'h1, 0);
    s4(0, 1, 3'b001, 4'h0, 0, "load_0",  4'h0, 0);
    s4(0, 1, 3'b101, 4'h7, 1, "dec_wrap", 4'hF, 1);
    s4(0, 1, 3'b101, 4'h7, 1, "dec_E",   4'hE, 0);
    s4(0, 0, 3'b100, 4'h5, 1, "ce0_a",   4'hE, 0);
    s4(0, 0, 3'b001, 4'h5, 1, "ce0_b",   4'hE, 0);
    s4(0, 0, 3'bxxx, 4'h5, 1, "ce0_x",   4'hE, 0);
    s4(0, 1, 3'b001, 4'h0, 0, "load_0b", 4'h0, 0);
    s4(0, 1, 3'b101, 4'h0, 0, "dec_b",   4'hF, 1);
    s4(0, 1, 3'b000, 4'h3, 1, "hold_sticky", 4'hF, 1);
    s4(0, 0, 3'b110, 4'h3, 1, "ce0_sticky",  4'hF, 1);
    s4(0, 1, 3'b001, 4'h9, 0, "load_9",  4'h9, 0);
    s4(0, 1, 3'b010, 4'hF, 0, "shl",     4'h2, 1);
    s4(0, 1, 3'b011, 4'hF, 1, "shr",     4'h9, 0);
    s4(0, 1, 3'b111, 4'h0, 0, "ror",     4'hC, 1);
    s4(0, 1, 3'b110, 4'h0, 0, "rol",     4'h9, 1);
    s4(0, 1, 3'b010, 4'h0, 1, "shl_sin1", 4'h3, 1);
    s4(0, 1, 3'b111, 4'h0, 1, "ror_b",   4'h9, 1);
    s4(0, 1, 3'b011, 4'h0, 0, "shr_sin0", 4'h4, 1);
    s4(1, 0, 3'b100, 4'h0, 0, "clr_ce0", 4'h0, 0);
    ce4 = 1'b0; clr4 = 1'b0;
    s8(1, 0, 3'b000, 8'h00, 0, "w8_clr",  8'h5A, 0);
    s8(0, 1, 3'b001, 8'h80, 0, "w8_load", 8'h80, 0);
    s8(1, 1, 3'b100, 8'h00, 0, "w8_clr_inc", 8'h5A, 0);
    s8(0, 1, 3'b100, 8'h00, 0, "w8_inc",  8'h5B, 0);
    s8(0, 1, 3'b001, 8'hFF, 0, "w8_loadFF", 8'hFF, 0);
    s8(0, 1, 3'b100, 8'h00, 0, "w8_inc_wrap", 8'h00, 1);
    s8(0, 1, 3'b101, 8'h00, 0, "w8_dec_wrap", 8'hFF, 1);
    s8(0, 1, 3'b001, 8'h81, 0, "w8_load81", 8'h81, 0);
    s8(0, 1, 3'b110, 8'h00, 1, "w8_rol",  8'h03, 1);
    s8(0, 1, 3'b111, 8'h00, 0, "w8_ror",  8'h81, 1);
    s8(0, 1, 3'b011, 8'h00, 0, "w8_shr",  8'h40, 1);
    s8(0, 1, 3'b010, 8'h00, 1, "w8_shl",  8'h81, 0);
    chk("w4_idle.q", 32'(q4), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pm_univ_reg.md
Name: pm_univ_reg

Overview:
- Parametrised successor to the team's 4-bit clear/enable data register: a WIDTH-bit universal register with eight operating modes (hold, load, shift, rotate, increment, decrement).
- Used as accumulator, program counter and serial shifter in the micro-processor datapath.
- Replaces fixed-width enable-only registers where the same storage must also count or shift.
- Adds a registered carry/shift-out flag and a zero flag.

Parameters:
- WIDTH, 4, data width in bits; legal range 2..32.
- RESET_VAL, 0, value loaded into q on clr; WIDTH bits, upper bits ignored if wider.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  reset; synchronous, active-high, highest priority.
- ce  input  1  clock enable; 0 = every register holds.
- mode  input  3  operation select; meaningful only when ce=1.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input for the shift modes.
- q  output  WIDTH  register contents.
- cout  output  1  registered carry, borrow or shifted-out bit.
- zero  output  1  combinational; 1 when q == 0.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on clr. No asynchronous paths exist.
- Priority at each rising clk edge:
  - clr=1: q <= RESET_VAL, cout <= 0. This applies regardless of ce and mode.
  - else ce=0: q and cout hold.
  - else ce=1: the mode table below applies.
- Mode table with ce=1. Each entry gives the q update and the cout update.
  - 000 hold: q holds; cout holds.
  - 001 load: q <= d; cout <= 0.
  - 010 shift left: q <= {q[W-2:0], sin}; cout <= q[W-1].
  - 011 shift right: q <= {sin, q[W-1:1]}; cout <= q[0].
  - 100 increment: q <= q+1 modulo 2^W; cout <= 1 iff old q is all ones (wrap to 0).
  - 101 decrement: q <= q-1 modulo 2^W; cout <= 1 iff old q == 0 (borrow, wrap to all ones).
  - 110 rotate left: q <= {q[W-2:0], q[W-1]}; cout <= q[W-1].
  - 111 rotate right: q <= {q[0], q[W-1:1]}; cout <= q[0].
- Latency: one cycle from a sampled input to q and cout. zero follows q combinationally, so it is valid in the same cycle q changes.
- Arithmetic: unsigned, modulo 2^WIDTH. No saturation. cout is the only overflow indication.
- Signal dependencies:
  - sin is ignored outside modes 010 and 011.
  - d is ignored outside mode 001.
- Reset state: q = RESET_VAL, cout = 0, zero = (RESET_VAL == 0).
- Reset mid-operation: clr asserted during any mode overrides that cycle's operation. Normal operation resumes on the first edge with clr=0.
- X on mode while ce=0 has no effect. X on mode while ce=1 is undefined and is not a legal stimulus.
- cout is sticky across hold cycles (mode 000 or ce=0). It is rewritten by every other active mode.
- No combinational path exists from any input to q or cout. The only combinational output is zero, which depends on q alone.

Test Plan:
1. WIDTH=4, RESET_VAL=0. Drive clr=1 with ce=1, mode=001, d=4'hA -> after the edge, q=0, cout=0, zero=1 (clr has priority over load).
2. Load 4'hE; then increment twice -> q=F, cout=0; then q=0, cout=1, zero=1. One more increment -> q=1, cout=0.
3. Load 0; decrement once -> q=F, cout=1. Decrement again -> q=E, cout=0. Set ce=0 for 3 cycles -> q=E and cout=0 unchanged.
4. Load 4'b1001; shift left with sin=0 -> q=0010, cout=1. Shift right with sin=1 -> q=1001, cout=0. Rotate right -> q=1100, cout=1. Rotate left -> q=1001, cout=1.
5. WIDTH=8, RESET_VAL=8'h5A. Pulse clr -> q=5A. Load 8'h80; assert clr in the same cycle as mode=100 -> q=5A, cout=0. Next cycle with mode=100 -> q=5B.
6. Sweep: random mode/ce/clr/d/sin for 10k cycles against a reference model -> q, cout and zero match on every cycle.
